// File: rtl/axil4_pkg.sv
// rtl/axil4_pkg.sv - shared constants and FSM encoding for the 128-bit AXI-Lite-4 line link
package axil4_pkg;

    localparam int AXIL_ADDR_W = 32;
    localparam int AXIL_DATA_W = 128;
    localparam int AXIL_STRB_W = AXIL_DATA_W / 8;

    // Write-response message meaning "no error"; anything else is an error.
    localparam logic [31:0] AXIL_MSG_OKAY = 32'h0;

    // Byte-offset bits inside one 16-byte line; cleared on every request address.
    localparam logic [31:0] LINE_OFFSET_MASK = 32'h0000_000F;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_ADDR = 3'd1;
    localparam logic [2:0] ST_RD_DATA = 3'd2;
    localparam logic [2:0] ST_WR_REQ  = 3'd3;
    localparam logic [2:0] ST_WR_RESP = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

endpackage

// File: rtl/axil4_line_master.sv
// rtl/axil4_line_master.sv - cache-side initiator turning one line request into an AXI-Lite-4 transaction
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_*                    line request from the cache (valid/ready, write flag, addr, data, strb)
//   resp_*                   one-cycle completion pulse with read data and error flag
//   readAddr_*, readData_*   read address / read data channels
//   writeAddr_*, writeData_* write address / write data channels
//   writeResp_*              write response channel (msg != 0 means error)
module axil4_line_master
    import axil4_pkg::*;
#(
    parameter int ADDR_W         = AXIL_ADDR_W,
    parameter int DATA_W         = AXIL_DATA_W,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,

    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,

    output logic [ADDR_W-1:0]   readAddr_addr,
    output logic                readAddr_valid,
    input  logic                readAddr_ready,

    input  logic [DATA_W-1:0]   readData_data,
    input  logic                readData_valid,
    output logic                readData_ready,

    output logic [ADDR_W-1:0]   writeAddr_addr,
    output logic                writeAddr_valid,
    input  logic                writeAddr_ready,

    output logic [DATA_W-1:0]   writeData_data,
    output logic [DATA_W/8-1:0] writeData_strb,
    output logic                writeData_valid,
    input  logic                writeData_ready,

    input  logic [31:0]         writeResp_msg,
    input  logic                writeResp_valid,
    output logic                writeResp_ready
);

    logic [2:0]          state_q,   state_d;
    logic [31:0]         cnt_q,     cnt_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic [DATA_W-1:0]   wdata_q,   wdata_d;
    logic [DATA_W/8-1:0] wstrb_q,   wstrb_d;
    logic                wa_pend_q, wa_pend_d;
    logic                wd_pend_q, wd_pend_d;
    logic [DATA_W-1:0]   rdata_q,   rdata_d;
    logic                err_q,     err_d;

    logic aw_hs;
    logic wd_hs;
    logic timeout_hit;

    assign aw_hs = wa_pend_q && writeAddr_ready;
    assign wd_hs = wd_pend_q && writeData_ready;

    // cnt_q holds the number of cycles since acceptance, so the abort takes
    // effect exactly TIMEOUT_CYCLES cycles after the request was taken.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q >= 32'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        wa_pend_d = wa_pend_q;
        wd_pend_d = wd_pend_q;
        // Completion payload is only loaded on entry to DONE, so it reads 0 elsewhere.
        rdata_d   = '0;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (req_valid) begin
                    addr_d  = req_addr & ~ADDR_W'(LINE_OFFSET_MASK);
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    cnt_d   = 32'd1;
                    if (req_write) begin
                        state_d   = ST_WR_REQ;
                        wa_pend_d = 1'b1;
                        wd_pend_d = 1'b1;
                    end else begin
                        state_d = ST_RD_ADDR;
                    end
                end
            end
            ST_RD_ADDR: begin
                cnt_d = cnt_q + 32'd1;
                if (readAddr_ready) begin
                    state_d = ST_RD_DATA;
                end else if (timeout_hit) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end
            end
            ST_RD_DATA: begin
                cnt_d = cnt_q + 32'd1;
                if (readData_valid) begin
                    state_d = ST_DONE;
                    rdata_d = readData_data;
                end else if (timeout_hit) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end
            end
            ST_WR_REQ: begin
                cnt_d = cnt_q + 32'd1;
                if (aw_hs) wa_pend_d = 1'b0;
                if (wd_hs) wd_pend_d = 1'b0;
                if ((!wa_pend_q || aw_hs) && (!wd_pend_q || wd_hs)) begin
                    state_d = ST_WR_RESP;
                end else if (!aw_hs && !wd_hs && timeout_hit) begin
                    // Any progress this cycle defers the abort by a cycle.
                    state_d   = ST_DONE;
                    err_d     = 1'b1;
                    wa_pend_d = 1'b0;
                    wd_pend_d = 1'b0;
                end
            end
            ST_WR_RESP: begin
                cnt_d = cnt_q + 32'd1;
                if (writeResp_valid) begin
                    state_d = ST_DONE;
                    err_d   = (writeResp_msg != AXIL_MSG_OKAY);
                end else if (timeout_hit) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end
            end
            ST_DONE: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wa_pend_q <= 1'b0;
            wd_pend_q <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            wa_pend_q <= wa_pend_d;
            wd_pend_q <= wd_pend_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign req_ready       = (state_q == ST_IDLE);
    assign readAddr_valid  = (state_q == ST_RD_ADDR);
    assign readData_ready  = (state_q == ST_RD_DATA);
    assign writeResp_ready = (state_q == ST_WR_RESP);
    assign resp_valid      = (state_q == ST_DONE);

    assign writeAddr_valid = wa_pend_q;
    assign writeData_valid = wd_pend_q;

    assign readAddr_addr   = addr_q;
    assign writeAddr_addr  = addr_q;
    assign writeData_data  = wdata_q;
    assign writeData_strb  = wstrb_q;

    assign resp_rdata      = rdata_q;
    assign resp_err        = err_q;

endmodule

// File: tb/tb_axil4_line_master.sv
// tb/tb_axil4_line_master.sv - self-checking bench for axil4_line_master
module tb_axil4_line_master;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         req_valid, req_ready, req_write;
    logic [31:0]  req_addr;
    logic [127:0] req_wdata;
    logic [15:0]  req_wstrb;
    logic         resp_valid, resp_err;
    logic [127:0] resp_rdata;
    logic [31:0]  readAddr_addr;
    logic         readAddr_valid, readAddr_ready;
    logic [127:0] readData_data;
    logic         readData_valid, readData_ready;
    logic [31:0]  writeAddr_addr;
    logic         writeAddr_valid, writeAddr_ready;
    logic [127:0] writeData_data;
    logic [15:0]  writeData_strb;
    logic         writeData_valid, writeData_ready;
    logic [31:0]  writeResp_msg;
    logic         writeResp_valid, writeResp_ready;

    logic         req_valid_t, req_ready_t, req_write_t;
    logic [31:0]  req_addr_t;
    logic [127:0] req_wdata_t;
    logic [15:0]  req_wstrb_t;
    logic         resp_valid_t, resp_err_t;
    logic [127:0] resp_rdata_t;
    logic [31:0]  readAddr_addr_t;
    logic         readAddr_valid_t, readAddr_ready_t;
    logic [127:0] readData_data_t;
    logic         readData_valid_t, readData_ready_t;
    logic [31:0]  writeAddr_addr_t;
    logic         writeAddr_valid_t, writeAddr_ready_t;
    logic [127:0] writeData_data_t;
    logic [15:0]  writeData_strb_t;
    logic         writeData_valid_t, writeData_ready_t;
    logic [31:0]  writeResp_msg_t;
    logic         writeResp_valid_t, writeResp_ready_t;

    axil4_line_master dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .readAddr_addr(readAddr_addr), .readAddr_valid(readAddr_valid), .readAddr_ready(readAddr_ready),
        .readData_data(readData_data), .readData_valid(readData_valid), .readData_ready(readData_ready),
        .writeAddr_addr(writeAddr_addr), .writeAddr_valid(writeAddr_valid), .writeAddr_ready(writeAddr_ready),
        .writeData_data(writeData_data), .writeData_strb(writeData_strb),
        .writeData_valid(writeData_valid), .writeData_ready(writeData_ready),
        .writeResp_msg(writeResp_msg), .writeResp_valid(writeResp_valid), .writeResp_ready(writeResp_ready)
    );

    axil4_line_master #(.TIMEOUT_CYCLES(8)) dut_t (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_t), .req_ready(req_ready_t), .req_write(req_write_t),
        .req_addr(req_addr_t), .req_wdata(req_wdata_t), .req_wstrb(req_wstrb_t),
        .resp_valid(resp_valid_t), .resp_rdata(resp_rdata_t), .resp_err(resp_err_t),
        .readAddr_addr(readAddr_addr_t), .readAddr_valid(readAddr_valid_t), .readAddr_ready(readAddr_ready_t),
        .readData_data(readData_data_t), .readData_valid(readData_valid_t), .readData_ready(readData_ready_t),
        .writeAddr_addr(writeAddr_addr_t), .writeAddr_valid(writeAddr_valid_t), .writeAddr_ready(writeAddr_ready_t),
        .writeData_data(writeData_data_t), .writeData_strb(writeData_strb_t),
        .writeData_valid(writeData_valid_t), .writeData_ready(writeData_ready_t),
        .writeResp_msg(writeResp_msg_t), .writeResp_valid(writeResp_valid_t), .writeResp_ready(writeResp_ready_t)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] flags();
        return {req_ready, readAddr_valid, readData_ready, writeAddr_valid,
                writeData_valid, writeResp_ready, resp_valid, resp_err};
    endfunction

    task automatic slave_idle();
        readAddr_ready  = 1'b0;
        readData_valid  = 1'b0;
        writeAddr_ready = 1'b0;
        writeData_ready = 1'b0;
        writeResp_valid = 1'b0;
        readData_data   = {$urandom, $urandom, $urandom, $urandom};
        writeResp_msg   = $urandom;
    endtask

    // One transaction on the main DUT. Each slave channel answers after the
    // given number of cycles of seeing valid/ready; ok collects every protocol
    // rule observed along the way.
    task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [127:0] wdata,
                          input logic [15:0] wstrb, input logic [127:0] rdata, input logic [31:0] msg,
                          input int ar_d, input int r_d, input int aw_d, input int w_d, input int b_d,
                          output int lat, output logic err, output logic [127:0] rd, output logic ok);
        int arw = 0, rw = 0, aww = 0, ww = 0, bw = 0;
        bit ar_done = 0, aw_done = 0, w_done = 0;
        logic [31:0] ea;
        ea  = {addr[31:4], 4'h0};
        ok  = 1'b1;
        lat = -1;
        err = 1'bx;
        rd  = 'x;
        @(negedge clk);
        if (!req_ready) ok = 1'b0;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
        @(negedge clk);
        req_valid = 1'b0;
        req_write = $urandom; req_addr = $urandom; req_wdata = {$urandom, $urandom, $urandom, $urandom};
        req_wstrb = $urandom;
        for (int c = 1; c < 200; c++) begin
            slave_idle();
            if (resp_valid) begin
                lat = c; err = resp_err; rd = resp_rdata;
                if (readAddr_valid | readData_ready | writeAddr_valid | writeData_valid | writeResp_ready | req_ready)
                    ok = 1'b0;
                break;
            end
            if (req_ready) ok = 1'b0;
            if (!wr && (writeAddr_valid | writeData_valid | writeResp_ready)) ok = 1'b0;
            if (wr && (readAddr_valid | readData_ready)) ok = 1'b0;
            if (readAddr_valid) begin
                if (ar_done || readAddr_addr !== ea) ok = 1'b0;
                if (arw == ar_d) begin readAddr_ready = 1'b1; ar_done = 1; end
                arw++;
            end
            if (readData_ready) begin
                if (!ar_done) ok = 1'b0;
                if (rw == r_d) begin readData_valid = 1'b1; readData_data = rdata; end
                rw++;
            end
            if (writeAddr_valid) begin
                if (aw_done || writeAddr_addr !== ea) ok = 1'b0;
                if (aww == aw_d) begin writeAddr_ready = 1'b1; aw_done = 1; end
                aww++;
            end
            if (writeData_valid) begin
                if (w_done || writeData_data !== wdata || writeData_strb !== wstrb) ok = 1'b0;
                if (ww == w_d) begin writeData_ready = 1'b1; w_done = 1; end
                ww++;
            end
            if (writeResp_ready) begin
                if (!(aw_done && w_done)) ok = 1'b0;
                if (bw == b_d) begin writeResp_valid = 1'b1; writeResp_msg = msg; end
                bw++;
            end
            @(negedge clk);
        end
        slave_idle();
        @(negedge clk);
        if (!req_ready || resp_valid) ok = 1'b0;
    endtask

    // Drive a request into the main DUT and assert rst once it reaches the
    // data/response phase.
    task automatic rst_mid(input logic wr, output logic reached);
        reached = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = 32'h300; req_wdata = '1; req_wstrb = 16'hFFFF;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            slave_idle();
            if ((!wr && readData_ready) || (wr && writeResp_ready)) begin
                reached = 1'b1;
                break;
            end
            readAddr_ready  = readAddr_valid;
            writeAddr_ready = writeAddr_valid;
            writeData_ready = writeData_valid;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Transaction on the TIMEOUT_CYCLES=8 instance. ready_cyc/data_cyc pick the
    // cycle (after acceptance) where the read slave answers; -1 means never.
    task automatic to_txn(input logic wr, input int ready_cyc, input int data_cyc,
                          output int lat, output logic err, output logic [127:0] rd,
                          output int vcnt, output logic quiet);
        lat = -1; err = 1'bx; rd = 'x; vcnt = 0; quiet = 1'b0;
        @(negedge clk);
        req_valid_t = 1'b1; req_write_t = wr; req_addr_t = 32'h2000; req_wdata_t = '1; req_wstrb_t = 16'h00FF;
        @(negedge clk);
        req_valid_t = 1'b0;
        for (int c = 1; c < 40; c++) begin
            readAddr_ready_t = 1'b0;
            readData_valid_t = 1'b0;
            if (resp_valid_t) begin
                lat = c; err = resp_err_t; rd = resp_rdata_t;
                quiet = !(readAddr_valid_t | readData_ready_t | writeAddr_valid_t |
                          writeData_valid_t | writeResp_ready_t);
                break;
            end
            if (readAddr_valid_t | writeAddr_valid_t) vcnt++;
            if (c == ready_cyc && readAddr_valid_t) readAddr_ready_t = 1'b1;
            if (c == data_cyc && readData_ready_t) readData_valid_t = 1'b1;
            @(negedge clk);
        end
        readAddr_ready_t = 1'b0;
        readData_valid_t = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [127:0] wdata;
        logic [15:0]  wstrb;
        logic [127:0] rdata;
        logic [31:0]  msg;
        int           ar_d, r_d, aw_d, w_d, b_d;
        int           exp_lat;
        logic         exp_err;
        logic [127:0] exp_rd;
    } vec_t;

    localparam logic [127:0] RD0 = 128'hDEAD0000_11112222_33334444_5555BEEF;
    localparam logic [127:0] RD3 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] RD6 = 128'hA5A5_A5A5_5A5A_5A5A_0F0F_0F0F_F0F0_F0F0;
    localparam logic [127:0] WD1 = 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555;
    localparam logic [127:0] WD2 = 128'h8000_0000_0000_0000_0000_0000_0000_0001;

    initial begin
        vec_t vecs[7];
        int lat, vcnt;
        logic err, ok, quiet, reached;
        logic [127:0] rd;

        rst = 1'b1;
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
        slave_idle();
        req_valid_t = 0; req_write_t = 0; req_addr_t = 0; req_wdata_t = 0; req_wstrb_t = 0;
        readAddr_ready_t = 0; readData_valid_t = 0; readData_data_t = RD3;
        writeAddr_ready_t = 0; writeData_ready_t = 0; writeResp_valid_t = 0; writeResp_msg_t = 0;

        repeat (3) @(negedge clk);
        chk("rst_flags", flags(), 8'b1000_0000);
        chk("rst_addr", {readAddr_addr, writeAddr_addr, writeData_strb}, '0);
        chk("rst_wdata", writeData_data, '0);
        chk("rst_rdata", resp_rdata, '0);
        rst = 1'b0;

        vecs[0] = '{1'b0, 32'h0000_1234, 128'h0, 16'h0,    RD0,   32'h0,         0, 0, 0, 0, 0,  3, 1'b0, RD0};
        vecs[1] = '{1'b1, 32'h0000_0040, WD1,    16'hFFFF, 128'h0, 32'h0,        0, 0, 3, 0, 0,  6, 1'b0, 128'h0};
        vecs[2] = '{1'b1, 32'h0000_0080, WD2,    16'h00F0, 128'h0, 32'h1,        0, 0, 0, 0, 0,  3, 1'b1, 128'h0};
        vecs[3] = '{1'b0, 32'h0000_5678, 128'h0, 16'h0,    RD3,   32'h0,        10, 5, 0, 0, 0, 18, 1'b0, RD3};
        vecs[4] = '{1'b1, 32'h0000_00C4, WD1,    16'h0000, 128'h0, 32'h0,        0, 0, 0, 0, 2,  5, 1'b0, 128'h0};
        vecs[5] = '{1'b1, 32'h1000_000F, WD2,    16'h8001, 128'h0, 32'hFFFF_FFFF, 0, 0, 0, 2, 0,  5, 1'b1, 128'h0};
        vecs[6] = '{1'b0, 32'hFFFF_FFFF, 128'h0, 16'h0,    RD6,   32'h0,         2, 1, 0, 0, 0,  6, 1'b0, RD6};

        for (int i = 0; i < 7; i++) begin
            do_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].rdata, vecs[i].msg,
                   vecs[i].ar_d, vecs[i].r_d, vecs[i].aw_d, vecs[i].w_d, vecs[i].b_d, lat, err, rd, ok);
            chk($sformatf("vec%0d_lat", i), 128'(lat), 128'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_err", i), 128'(err), 128'(vecs[i].exp_err));
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_proto", i), 128'(ok), 128'(1));
        end

        // Stray slave activity while idle must be ignored.
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (flags() !== 8'b1000_0000) ok = 1'b0;
            readAddr_ready = 1; readData_valid = 1; writeAddr_ready = 1; writeData_ready = 1; writeResp_valid = 1;
        end
        @(negedge clk);
        if (flags() !== 8'b1000_0000) ok = 1'b0;
        slave_idle();
        chk("stray_idle", 128'(ok), 128'(1));

        // Randomized traffic against a latency/result model built from the channel rules.
        for (int i = 0; i < 40; i++) begin
            logic         wr;
            logic [31:0]  addr, msg;
            logic [127:0] wdata, rdata;
            logic [15:0]  wstrb;
            int ar_d, r_d, aw_d, w_d, b_d, exp_lat;
            wr = $urandom; addr = $urandom; msg = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
            wdata = {$urandom, $urandom, $urandom, $urandom}; rdata = {$urandom, $urandom, $urandom, $urandom};
            wstrb = $urandom;
            ar_d = $urandom_range(0, 4); r_d = $urandom_range(0, 4);
            aw_d = $urandom_range(0, 4); w_d = $urandom_range(0, 4); b_d = $urandom_range(0, 4);
            exp_lat = wr ? 3 + ((aw_d > w_d) ? aw_d : w_d) + b_d : 3 + ar_d + r_d;
            do_txn(wr, addr, wdata, wstrb, rdata, msg, ar_d, r_d, aw_d, w_d, b_d, lat, err, rd, ok);
            chk($sformatf("rnd%0d_lat", i), 128'(lat), 128'(exp_lat));
            chk($sformatf("rnd%0d_err", i), 128'(err), 128'(wr ? (msg != 32'h0) : 1'b0));
            chk($sformatf("rnd%0d_rdata", i), rd, wr ? 128'h0 : rdata);
            chk($sformatf("rnd%0d_proto", i), 128'(ok), 128'(1));
        end

        // Reset in RD_DATA and in WR_RESP, each followed by a clean transaction.
        for (int k = 0; k < 2; k++) begin
            rst_mid(k[0], reached);
            chk($sformatf("rstmid%0d_reached", k), 128'(reached), 128'(1));
            chk($sformatf("rstmid%0d_flags", k), flags(), 8'b1000_0000);
            chk($sformatf("rstmid%0d_addr", k), {readAddr_addr, writeAddr_addr, writeData_strb}, '0);
            chk($sformatf("rstmid%0d_wdata", k), writeData_data, '0);
            chk($sformatf("rstmid%0d_rdata", k), resp_rdata, '0);
            rst = 1'b0;
            do_txn(1'b0, 32'h0000_0A5C, 128'h0, 16'h0, RD6, 32'h0, 0, 0, 0, 0, 0, lat, err, rd, ok);
            chk($sformatf("rstmid%0d_after_lat", k), 128'(lat), 128'(3));
            chk($sformatf("rstmid%0d_after_rdata", k), rd, RD6);
            chk($sformatf("rstmid%0d_after_proto", k), 128'(ok), 128'(1));
        end

        // Timeout instance: read with silent slave.
        to_txn(1'b0, -1, -1, lat, err, rd, vcnt, quiet);
        chk("to_rd_lat", 128'(lat), 128'(8));
        chk("to_rd_err", 128'(err), 128'(1));
        chk("to_rd_rdata", rd, 128'h0);
        chk("to_rd_vcnt", 128'(vcnt), 128'(7));
        chk("to_rd_quiet", 128'(quiet), 128'(1));

        // Handshake on the timeout cycle wins; the data beat on the next timeout cycle wins too.
        to_txn(1'b0, 7, 8, lat, err, rd, vcnt, quiet);
        chk("to_win_lat", 128'(lat), 128'(9));
        chk("to_win_err", 128'(err), 128'(0));
        chk("to_win_rdata", rd, RD3);

        // Write with silent slave.
        to_txn(1'b1, -1, -1, lat, err, rd, vcnt, quiet);
        chk("to_wr_lat", 128'(lat), 128'(8));
        chk("to_wr_err", 128'(err), 128'(1));
        chk("to_wr_vcnt", 128'(vcnt), 128'(7));
        chk("to_wr_quiet", 128'(quiet), 128'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
